// File: rtl/sdram_pll_pkg.sv
// Shared types and constants for the SDRAM PLL reset controller.
// The optional lock-loss counter is enabled by SDRAM_PLL_LOSS_CNT_EN.
package sdram_pll_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 27;
    localparam int DEF_LOCK_TIMEOUT  = 27000;
    localparam int DEF_STABLE_CYCLES = 2700;
    localparam int DEF_MAX_RETRIES   = 7;
    localparam int DEF_CNT_W         = 16;

    localparam int RETRY_W = 3;
    localparam int LOSS_W  = 8;

    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_pll_sync.sv
// Two-flop synchroniser for signals arriving asynchronously to clk_i.
module sdram_pll_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sdram_pll_reset_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases sys_rst.
// Define SDRAM_PLL_LOSS_CNT_EN to add the saturating loss_cnt port.
module sdram_pll_reset_ctrl
    import sdram_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               pll_ready,
    output logic               pll_fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef SDRAM_PLL_LOSS_CNT_EN
    ,
    output logic [LOSS_W-1:0]  loss_cnt
`endif
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic             lock_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic             take_retry;
    logic             pll_rst_q, sys_rst_q, pll_ready_q, pll_fail_q;

    sdram_pll_sync #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    // Lock beats timeout in WAIT; loss beats stable completion in STABLE.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        take_retry = 1'b0;
        case (state_q)
            HOLD: begin
                if (timer_q == RST_LAST) state_d = WAIT;
            end
            WAIT: begin
                if (lock_s)                      state_d    = STABLE;
                else if (timer_q == LOCK_LAST)   take_retry = 1'b1;
            end
            STABLE: begin
                if (!lock_s) begin
                    take_retry = 1'b1;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) state_d = HOLD;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        if (take_retry) begin
            if (retry_q == RETRY_MAX) begin
                state_d = FAIL;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = HOLD;
            end
        end

        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD;
            timer_q     <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == HOLD) || (state_d == FAIL);
            sys_rst_q   <= (state_d != RUN);
            pll_ready_q <= (state_d == RUN);
            pll_fail_q  <= (state_d == FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign pll_ready = pll_ready_q;
    assign pll_fail  = pll_fail_q;
    assign retry_cnt = retry_q;

`ifdef SDRAM_PLL_LOSS_CNT_EN
    logic [LOSS_W-1:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if ((state_q == RUN) && (state_d == HOLD)) loss_d = sat_inc_loss(loss_q);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) loss_q <= '0;
        else     loss_q <= loss_d;
    end

    assign loss_cnt = loss_q;
`endif

endmodule
